// File: rtl/snes_pad_reader_if.sv
// Host-side and pad-side signals of the SNES pad reader.
// Build option SECOND_PAD_EN adds the second pad's data line and button word.
interface snes_pad_reader_if #(
    parameter int NBITS = 12
);
    logic             frame_tick;
    logic             pad_data;
    logic             pad_latch;
    logic             pad_clk;
    logic [NBITS-1:0] buttons;
    logic             valid;
    logic             busy;
`ifdef SECOND_PAD_EN
    logic             pad_data_b;
    logic [NBITS-1:0] buttons_b;

    modport master (
        input  frame_tick, pad_data, pad_data_b,
        output pad_latch, pad_clk, buttons, buttons_b, valid, busy
    );
    modport slave (
        output frame_tick, pad_data, pad_data_b,
        input  pad_latch, pad_clk, buttons, buttons_b, valid, busy
    );
`else
    modport master (
        input  frame_tick, pad_data,
        output pad_latch, pad_clk, buttons, valid, busy
    );
    modport slave (
        output frame_tick, pad_data,
        input  pad_latch, pad_clk, buttons, valid, busy
    );
`endif
endinterface

// File: rtl/snes_pad_reader.sv
// Polls an SNES serial gamepad once per frame_tick and presents an active-high button word.
// Build option SECOND_PAD_EN reads a second pad on the same latch/clock timing.
module snes_pad_reader #(
    parameter int HALF_PERIOD = 4,
    parameter int NBITS       = 12
) (
    input logic               clk,
    input logic               rst,
    snes_pad_reader_if.master bus
);
    localparam int TW = $clog2(2 * HALF_PERIOD);
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [TW-1:0] LOW_LAST   = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] PHASE_LAST = TW'(2 * HALF_PERIOD - 1);
    localparam logic [TW-1:0] TCNT_ONE   = TW'(1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);
    localparam logic [BW-1:0] BIT_ONE    = BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [TW-1:0]    tcnt_r;
    logic [BW-1:0]    bit_r;
    logic [1:0]       sync_a_r;
    logic [NBITS-1:0] shift_a_r;
    logic [NBITS-1:0] buttons_r;
    logic             pad_latch_r;
    logic             pad_clk_r;
    logic             valid_r;
    logic             busy_r;
`ifdef SECOND_PAD_EN
    logic [1:0]       sync_b_r;
    logic [NBITS-1:0] shift_b_r;
    logic [NBITS-1:0] buttons_b_r;
`endif

    // Two-flop synchronizers; idle value 1 matches a released or unplugged pad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a_r <= 2'b11;
`ifdef SECOND_PAD_EN
            sync_b_r <= 2'b11;
`endif
        end else begin
            sync_a_r <= {sync_a_r[0], bus.pad_data};
`ifdef SECOND_PAD_EN
            sync_b_r <= {sync_b_r[0], bus.pad_data_b};
`endif
        end
    end

    // Poll sequencer: latch pulse, NBITS clock pulses, then one DONE cycle publishing the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            tcnt_r      <= {TW{1'b0}};
            bit_r       <= {BW{1'b0}};
            shift_a_r   <= {NBITS{1'b0}};
            buttons_r   <= {NBITS{1'b0}};
            pad_latch_r <= 1'b0;
            pad_clk_r   <= 1'b1;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
`ifdef SECOND_PAD_EN
            shift_b_r   <= {NBITS{1'b0}};
            buttons_b_r <= {NBITS{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.frame_tick) begin
                        state_r     <= LATCH;
                        busy_r      <= 1'b1;
                        pad_latch_r <= 1'b1;
                        tcnt_r      <= {TW{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LATCH: begin
                    if (tcnt_r == PHASE_LAST) begin
                        state_r     <= SHIFT;
                        pad_latch_r <= 1'b0;
                        pad_clk_r   <= 1'b0;
                        tcnt_r      <= {TW{1'b0}};
                        bit_r       <= {BW{1'b0}};
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_ONE;
                    end
                end
                SHIFT: begin
                    // Sample just before the rising pad_clk edge moves the pad to the next bit.
                    if (tcnt_r == LOW_LAST) begin
                        shift_a_r[bit_r] <= ~sync_a_r[1];
`ifdef SECOND_PAD_EN
                        shift_b_r[bit_r] <= ~sync_b_r[1];
`endif
                        pad_clk_r <= 1'b1;
                    end else begin
                        pad_clk_r <= pad_clk_r;
                    end
                    if (tcnt_r == PHASE_LAST) begin
                        tcnt_r <= {TW{1'b0}};
                        if (bit_r == BIT_LAST) begin
                            state_r   <= DONE;
                            buttons_r <= shift_a_r;
`ifdef SECOND_PAD_EN
                            buttons_b_r <= shift_b_r;
`endif
                            valid_r   <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            bit_r     <= bit_r + BIT_ONE;
                            pad_clk_r <= 1'b0;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_ONE;
                    end
                end
                DONE: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    pad_latch_r <= 1'b0;
                    pad_clk_r   <= 1'b1;
                    valid_r     <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.buttons   = buttons_r;
    assign bus.valid     = valid_r;
    assign bus.busy      = busy_r;
    assign bus.pad_latch = pad_latch_r;
    assign bus.pad_clk   = pad_clk_r;
`ifdef SECOND_PAD_EN
    assign bus.buttons_b = buttons_b_r;
`endif

endmodule

// File: tb/tb_snes_pad_reader.sv
// Self-checking bench for snes_pad_reader: a behavioural SNES pad model plus table, hand and random polls.
module tb_snes_pad_reader;
    localparam int HP  = 4;
    localparam int NB  = 12;
    localparam int LAT = 2 * HP * (NB + 1) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snes_pad_reader_if #(.NBITS(NB)) bus ();
    snes_pad_reader #(.HALF_PERIOD(HP), .NBITS(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Pad model: a pressed button pulls its data bit low; latch reloads, each rising pad_clk advances.
    logic [NB-1:0] pad_word_a = '0;
    logic [NB-1:0] pad_word_b = '0;
    logic [NB-1:0] sh_a, sh_b;
    int            pad_idx = 0;

    always @(posedge bus.pad_latch or posedge bus.pad_clk) begin
        if (bus.pad_latch) pad_idx <= 0;
        else               pad_idx <= pad_idx + 1;
    end
    assign sh_a = pad_word_a >> pad_idx;
    assign sh_b = pad_word_b >> pad_idx;
    assign bus.pad_data = (pad_idx < NB) ? ~sh_a[0] : 1'b1;
`ifdef SECOND_PAD_EN
    assign bus.pad_data_b = (pad_idx < NB) ? ~sh_b[0] : 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a poll at a negedge (cycle 0) and observes cycles 1..LAT+15.
    task automatic run_poll(input logic [NB-1:0] wa, input logic [NB-1:0] wb,
                            input logic [NB-1:0] ea, input logic [NB-1:0] eb,
                            input int t1, input int t2);
        int   vcnt, vcyc, lcnt, lfirst, pulses, busy1, busy_at_v;
        logic prev_clk;
        pad_word_a = wa;
        pad_word_b = wb;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        vcnt = 0; vcyc = -1; lcnt = 0; lfirst = -1; pulses = 0; busy_at_v = -1;
        prev_clk = 1'b1;
        busy1 = int'(bus.busy);
        for (int n = 1; n <= LAT + 15; n++) begin
            if (bus.valid) begin
                vcnt++;
                if (vcyc < 0) begin
                    vcyc = n;
                    busy_at_v = int'(bus.busy);
                end
            end
            if (bus.pad_latch) begin
                lcnt++;
                if (lfirst < 0) lfirst = n;
            end
            if (prev_clk && !bus.pad_clk) pulses++;
            prev_clk = bus.pad_clk;
            bus.frame_tick = (n == t1) || (n == t2);
            @(negedge clk);
        end
        bus.frame_tick = 1'b0;
        check("busy_cycle1", busy1, 32'd1);
        check("latch_first", lfirst, 32'd1);
        check("latch_cycles", lcnt, 2 * HP);
        check("clk_pulses", pulses, NB);
        check("valid_count", vcnt, 32'd1);
        check("valid_cycle", vcyc, LAT);
        check("busy_at_valid", busy_at_v, 32'd0);
        check("buttons", 32'(bus.buttons), 32'(ea));
`ifdef SECOND_PAD_EN
        check("buttons_b", 32'(bus.buttons_b), 32'(eb));
`endif
        check("pad_clk_end", 32'(bus.pad_clk), 32'd1);
    endtask

    typedef struct {
        logic [NB-1:0] wa;
        logic [NB-1:0] wb;
        logic [NB-1:0] ea;
        logic [NB-1:0] eb;
        int            t1;
        int            t2;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int vcnt, lcnt, ccnt;
        logic [NB-1:0] w, v;
        tbl[0] = '{12'h010, 12'h020, 12'h010, 12'h020, 0, 0};
        tbl[1] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 0};
        tbl[2] = '{12'h000, 12'h000, 12'h000, 12'h000, 0, 0};
        tbl[3] = '{12'h100, 12'h200, 12'h100, 12'h200, 50, 105};
        tbl[4] = '{12'hA5A, 12'h5A5, 12'hA5A, 12'h5A5, 9, 0};
        tbl[5] = '{12'h801, 12'hC00, 12'h801, 12'hC00, 0, 0};

        rst = 1'b1;
        bus.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pad_clk", 32'(bus.pad_clk), 32'd1);
        check("rst_pad_latch", 32'(bus.pad_latch), 32'd0);
        check("rst_buttons", 32'(bus.buttons), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Idle with no tick: nothing moves.
        vcnt = 0; lcnt = 0; ccnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
            if (bus.pad_latch) lcnt++;
            if (!bus.pad_clk) ccnt++;
        end
        check("idle_valid", vcnt, 32'd0);
        check("idle_latch", lcnt, 32'd0);
        check("idle_clk_low", ccnt, 32'd0);
        check("idle_buttons", 32'(bus.buttons), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_poll(tbl[i].wa, tbl[i].wb, tbl[i].ea, tbl[i].eb, tbl[i].t1, tbl[i].t2);
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of a poll with Down pressed.
        pad_word_a = 12'h020;
        pad_word_b = 12'h010;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (59) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_pad_clk", 32'(bus.pad_clk), 32'd1);
        check("mid_rst_pad_latch", 32'(bus.pad_latch), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_valid", 32'(bus.valid), 32'd0);
        check("mid_rst_buttons", 32'(bus.buttons), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vcnt = 0;
        for (int n = 0; n < LAT; n++) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        check("post_rst_valid", vcnt, 32'd0);
        check("post_rst_buttons", 32'(bus.buttons), 32'd0);
        run_poll(12'h020, 12'h010, 12'h020, 12'h010, 0, 0);

        // Random polls against the pad model.
        for (int i = 0; i < 10; i++) begin
            w = NB'($urandom);
            v = NB'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            run_poll(w, v, w, v, int'($urandom_range(2, LAT)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
